bist_seq_ctrl: RTL and testbench
================================

// Module: bist_seq_ctrl
// PURPOSE
//  Sequencer upstream of the scan CUT, LFSR, MISR and comparator in the BIST top.
//  On START it runs a fixed number of scan patterns. Each pattern is N_SCAN shift cycles
//  followed by one capture cycle. It emits INIT to clear the LFSR/MISR, a FINISH pulse
//  so the comparator samples the signature, and BIST_END.
//  TEST_MODE drives the functional/test input mux. SCAN_EN drives the CUT scan enable.
// PARAMETERS
//  N_SCAN      8   scan chain length = shift cycles per pattern (>=1)
//  N_PATTERNS  16  number of shift+capture patterns per run (>=1)
// PORTS
//  CLK        in   1  clock; all state updates on the rising edge
//  RST        in   1  synchronous, active-low reset
//  START      in   1  level request to run BIST
//  TEST_MODE  out  1  high from INIT through FINISH; selects LFSR vectors into the CUT
//  SCAN_EN    out  1  high in SHIFT, low in all other states
//  INIT       out  1  one-cycle pulse at start of run; clears LFSR/MISR
//  RUNNING    out  1  high in INIT, SHIFT, CAPTURE and FINISH
//  FINISH     out  1  one-cycle pulse after last capture; comparator sample strobe
//  BIST_END   out  1  high in DONE
//  PAT_IDX    out  $clog2(N_PATTERNS+1)  current pattern index, 0-based
// BEHAVIOUR
//  - States: IDLE, INIT, SHIFT, CAPTURE, FINISH, DONE.
//  - Outputs are Moore-decoded from registered state and counters; no input-to-output paths.
//  - Reset (RST==0 at a rising edge):
//    - state=IDLE, shift_cnt=0, PAT_IDX=0.
//    - All 1-bit outputs read 0.
//    - Reset overrides every other input and aborts any run mid-operation.
//  - IDLE: if START==1, go to INIT. Otherwise stay.
//  - INIT: always lasts 1 cycle, then SHIFT. On entry, shift_cnt=0 and PAT_IDX=0.
//  - SHIFT:
//    - shift_cnt increments each cycle.
//    - When shift_cnt==N_SCAN-1, clear shift_cnt and go to CAPTURE.
//    - Result: exactly N_SCAN SHIFT cycles per pattern.
//  - CAPTURE: lasts 1 cycle (SCAN_EN=0, TEST_MODE=1).
//    - If PAT_IDX==N_PATTERNS-1, go to FINISH.
//    - Otherwise increment PAT_IDX and go to SHIFT.
//  - FINISH: lasts 1 cycle, then DONE.
//  - DONE:
//    - BIST_END=1 and PAT_IDX holds its final value.
//    - START==0: go to IDLE.
//    - START==1: stay in DONE. No retrigger without a START low phase.
//  - START is ignored outside IDLE and DONE. Dropping START mid-run does not abort the run.
//  - Run length: INIT through FINISH inclusive is 2 + N_PATTERNS*(N_SCAN+1) cycles.
//    The START edge that leaves IDLE is not included in this count.
//  - Counters never wrap. shift_cnt is at most N_SCAN-1; PAT_IDX is at most N_PATTERNS-1.
// TESTING
//  1. Reset with N_SCAN=3, N_PATTERNS=2:
//     - Hold RST=0 for 2 cycles with START=1.
//     - Required: all outputs 0, PAT_IDX=0.
//  2. Full run with N_SCAN=3, N_PATTERNS=2:
//     - Release reset, START=1 sampled at edge 0.
//     - Required: INIT high in cycle 1; SCAN_EN high in cycles 2-4 and 6-8; CAPTURE in cycles 5 and 9.
//     - Required: FINISH high in cycle 10 only; BIST_END high from cycle 11.
//     - Required: TEST_MODE and RUNNING high in cycles 1-10.
//  3. Hold and rearm:
//     - Keep START=1 for 5 cycles after cycle 11. Required: BIST_END stays 1 and no INIT.
//     - Drop START. Required: IDLE on the next cycle with BIST_END=0.
//     - Raise START again. Required: INIT exactly 1 cycle later.
//  4. START dropped mid-run:
//     - START=0 during SHIFT of pattern 0.
//     - Required: the run completes unchanged (FINISH still in cycle 10), then DONE.
//     - Required: IDLE on the following cycle because START==0.
//  5. Reset mid-run:
//     - Assert RST=0 in cycle 6 (SHIFT).
//     - Required: next cycle is IDLE, SCAN_EN=0, PAT_IDX=0, and no FINISH is ever emitted.
//  6. Minimum configuration N_SCAN=1, N_PATTERNS=1:
//     - Required: INIT, SHIFT, CAPTURE, FINISH in cycles 1-4, then DONE in cycle 5.
//  - All runs: check that PAT_IDX and SCAN_EN are never X after reset.

Source files
------------

// File: rtl/bist_seq_ctrl_if.sv
// rtl/bist_seq_ctrl_if.sv - start request and sequencing outputs between the BIST sequencer and the BIST top
//
// Signals:
//   start      level request to run BIST (driven by the slave side)
//   test_mode  functional/test input mux select
//   scan_en    CUT scan enable
//   init       one-cycle LFSR/MISR clear pulse
//   running    high while a run is in progress (INIT through FINISH)
//   finish     one-cycle comparator sample strobe
//   bist_end   high once a run has completed, until start is dropped
//   pat_idx    current pattern index, 0-based
// Modports:
//   master  the sequencer (drives the outputs, reads start)
//   slave   the BIST top (drives start, reads the outputs)

interface bist_seq_ctrl_if #(
    parameter int N_PATTERNS = 16
) ();
    localparam int PI_W = $clog2(N_PATTERNS + 1);

    logic            start;
    logic            test_mode;
    logic            scan_en;
    logic            init;
    logic            running;
    logic            finish;
    logic            bist_end;
    logic [PI_W-1:0] pat_idx;

    modport master (
        input  start,
        output test_mode,
        output scan_en,
        output init,
        output running,
        output finish,
        output bist_end,
        output pat_idx
    );

    modport slave (
        output start,
        input  test_mode,
        input  scan_en,
        input  init,
        input  running,
        input  finish,
        input  bist_end,
        input  pat_idx
    );
endinterface

// File: rtl/bist_seq_ctrl.sv
// rtl/bist_seq_ctrl.sv - BIST scan sequencer: INIT, N_PATTERNS x (N_SCAN shifts + capture), FINISH, DONE
//
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   synchronous active-low reset; aborts any run
//   bus   bist_seq_ctrl_if master: start in; test_mode, scan_en, init,
//         running, finish, bist_end, pat_idx out
// Parameters:
//   N_SCAN      shift cycles per pattern (>=1)
//   N_PATTERNS  patterns per run (>=1)

module bist_seq_ctrl #(
    parameter int N_SCAN     = 8,
    parameter int N_PATTERNS = 16
) (
    input  logic             clk,
    input  logic             rst,
    bist_seq_ctrl_if.master  bus
);
    localparam int SC_W = (N_SCAN > 1) ? $clog2(N_SCAN) : 1;
    localparam int PI_W = $clog2(N_PATTERNS + 1);

    localparam logic [SC_W-1:0] SC_LAST = SC_W'(N_SCAN - 1);
    localparam logic [PI_W-1:0] PI_LAST = PI_W'(N_PATTERNS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_SHIFT   = 3'd2,
        S_CAPTURE = 3'd3,
        S_FINISH  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    typedef struct packed {
        logic test_mode;
        logic scan_en;
        logic init;
        logic running;
        logic finish;
        logic bist_end;
    } outs_t;

    state_t          state;
    logic [SC_W-1:0] shift_cnt;
    logic [PI_W-1:0] pat_idx;
    outs_t           outs_q;

    // Output flags for a given state. Registered alongside the state
    // transition so the outputs are pure flops with no input-to-output path.
    function automatic outs_t decode(input state_t s);
        outs_t o;
        o = '0;
        case (s)
            S_INIT: begin
                o.test_mode = 1'b1;
                o.init      = 1'b1;
                o.running   = 1'b1;
            end
            S_SHIFT: begin
                o.test_mode = 1'b1;
                o.scan_en   = 1'b1;
                o.running   = 1'b1;
            end
            S_CAPTURE: begin
                o.test_mode = 1'b1;
                o.running   = 1'b1;
            end
            S_FINISH: begin
                o.test_mode = 1'b1;
                o.running   = 1'b1;
                o.finish    = 1'b1;
            end
            S_DONE: begin
                o.bist_end  = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            shift_cnt <= '0;
            pat_idx   <= '0;
            outs_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state     <= S_INIT;
                        shift_cnt <= '0;
                        pat_idx   <= '0;
                        outs_q    <= decode(S_INIT);
                    end
                end
                S_INIT: begin
                    state  <= S_SHIFT;
                    outs_q <= decode(S_SHIFT);
                end
                S_SHIFT: begin
                    if (shift_cnt == SC_LAST) begin
                        shift_cnt <= '0;
                        state     <= S_CAPTURE;
                        outs_q    <= decode(S_CAPTURE);
                    end else begin
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    // pat_idx advances only when another pattern follows,
                    // so it never exceeds N_PATTERNS-1 and holds in DONE.
                    if (pat_idx == PI_LAST) begin
                        state  <= S_FINISH;
                        outs_q <= decode(S_FINISH);
                    end else begin
                        pat_idx <= pat_idx + 1'b1;
                        state   <= S_SHIFT;
                        outs_q  <= decode(S_SHIFT);
                    end
                end
                S_FINISH: begin
                    state  <= S_DONE;
                    outs_q <= decode(S_DONE);
                end
                S_DONE: begin
                    // Requires start to drop before another run can begin.
                    if (!bus.start) begin
                        state  <= S_IDLE;
                        outs_q <= decode(S_IDLE);
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    shift_cnt <= '0;
                    pat_idx   <= '0;
                    outs_q    <= '0;
                end
            endcase
        end
    end

    assign bus.test_mode = outs_q.test_mode;
    assign bus.scan_en   = outs_q.scan_en;
    assign bus.init      = outs_q.init;
    assign bus.running   = outs_q.running;
    assign bus.finish    = outs_q.finish;
    assign bus.bist_end  = outs_q.bist_end;
    assign bus.pat_idx   = pat_idx;
endmodule

// File: tb/tb_bist_seq_ctrl.sv
// tb/tb_bist_seq_ctrl.sv - scoreboard bench for bist_seq_ctrl (N_SCAN=3/N_PATTERNS=2 and 1/1)

module tb_bist_seq_ctrl;
    logic clk;
    logic rst_a, rst_b;
    int   cyc = 0;

    bist_seq_ctrl_if #(.N_PATTERNS(2)) if_a ();
    bist_seq_ctrl_if #(.N_PATTERNS(1)) if_b ();

    bist_seq_ctrl #(.N_SCAN(3), .N_PATTERNS(2)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (if_a.master)
    );

    bist_seq_ctrl #(.N_SCAN(1), .N_PATTERNS(1)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (if_b.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {E_IDLE, E_INIT, E_SHIFT, E_CAP, E_FIN, E_DONE} est_t;

    typedef struct {
        int         at_cyc;
        bit         dut;
        logic [7:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // {test_mode, scan_en, init, running, finish, bist_end, pat_idx[1:0]}
    function automatic logic [7:0] ev(input est_t e, input int p);
        logic [5:0] o;
        case (e)
            E_INIT:  o = 6'b101100;
            E_SHIFT: o = 6'b110100;
            E_CAP:   o = 6'b100100;
            E_FIN:   o = 6'b100110;
            E_DONE:  o = 6'b000001;
            default: o = 6'b000000;
        endcase
        return {o, 2'(p)};
    endfunction

    // Drive inputs for the next rising edge and queue the state expected after it.
    task automatic step(input bit d, input logic r, input logic s, input est_t e, input int p);
        exp_t x;
        if (d) begin
            rst_b      = r;
            if_b.start = s;
        end else begin
            rst_a      = r;
            if_a.start = s;
        end
        x.at_cyc = cyc + 1;
        x.dut    = d;
        x.exp    = ev(e, p);
        sbq.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // One complete run on dut A starting from IDLE/DONE-exit; st_mid is
    // the start level held from the first SHIFT onwards.
    task automatic full_run_a(input logic st_mid);
        step(0, 1'b1, 1'b1, E_INIT, 0);
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 3; k++) step(0, 1'b1, st_mid, E_SHIFT, p);
            step(0, 1'b1, st_mid, E_CAP, p);
        end
        step(0, 1'b1, st_mid, E_FIN, 1);
        step(0, 1'b1, st_mid, E_DONE, 1);
    endtask

    // Monitor: outputs are presented every cycle, so compare at each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].at_cyc <= cyc) begin
                exp_t       x;
                logic [7:0] act;
                x = sbq.pop_front();
                n_checks++;
                if (x.dut)
                    act = {if_b.test_mode, if_b.scan_en, if_b.init, if_b.running,
                           if_b.finish, if_b.bist_end, 1'b0, if_b.pat_idx};
                else
                    act = {if_a.test_mode, if_a.scan_en, if_a.init, if_a.running,
                           if_a.finish, if_a.bist_end, if_a.pat_idx};
                if (x.at_cyc != cyc) begin
                    n_errors++;
                    $display("FAIL stale_entry dut=%0d at cycle %0d: expected for cycle %0d", x.dut, cyc, x.at_cyc);
                end else if (act !== x.exp) begin
                    n_errors++;
                    $display("FAIL outs dut=%0d cycle %0d: got %b, want %b (tm,se,init,run,fin,end,pat)",
                             x.dut, cyc, act, x.exp);
                end
            end
        end
    end

    initial begin
        rst_a      = 1'b0;
        if_a.start = 1'b1;
        rst_b      = 1'b0;
        if_b.start = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with start high
        step(0, 1'b0, 1'b1, E_IDLE, 0);
        step(0, 1'b0, 1'b1, E_IDLE, 0);

        // Full run, start held high
        full_run_a(1'b1);

        // Hold in DONE, then rearm
        for (int k = 0; k < 5; k++) step(0, 1'b1, 1'b1, E_DONE, 1);
        step(0, 1'b1, 1'b0, E_IDLE, 1);

        // Run with start dropped after INIT; completes, then IDLE
        full_run_a(1'b0);
        step(0, 1'b1, 1'b0, E_IDLE, 1);

        // Reset mid-run during SHIFT of pattern 1 (cycle 6)
        step(0, 1'b1, 1'b1, E_INIT, 0);
        for (int k = 0; k < 3; k++) step(0, 1'b1, 1'b1, E_SHIFT, 0);
        step(0, 1'b1, 1'b1, E_CAP, 0);
        step(0, 1'b1, 1'b1, E_SHIFT, 1);
        step(0, 1'b0, 1'b1, E_IDLE, 0);
        step(0, 1'b0, 1'b0, E_IDLE, 0);
        for (int k = 0; k < 12; k++) step(0, 1'b1, 1'b0, E_IDLE, 0);

        // Minimum configuration on dut B
        step(1, 1'b0, 1'b1, E_IDLE, 0);
        step(1, 1'b1, 1'b1, E_INIT, 0);
        step(1, 1'b1, 1'b1, E_SHIFT, 0);
        step(1, 1'b1, 1'b1, E_CAP, 0);
        step(1, 1'b1, 1'b1, E_FIN, 0);
        step(1, 1'b1, 1'b1, E_DONE, 0);
        step(1, 1'b1, 1'b1, E_DONE, 0);
        step(1, 1'b1, 1'b0, E_IDLE, 0);

        @(negedge clk);
        #1;
        n_checks++;
        if (sbq.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d entries left, want 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
